// File: rtl/transmission_if.sv
// transmission_if: host sample stream and DAC-side signals of the transmit player.
interface transmission_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        dac_valid;
    logic [31:0] dac_data;
    logic        busy;
    logic        underflow;
    logic [15:0] under_count;
    logic        irq;
    modport master (
        output s_valid, s_data, s_last, dac_valid,
        input  s_ready, dac_data, busy, underflow, under_count, irq
    );
    modport slave (
        input  s_valid, s_data, s_last, dac_valid,
        output s_ready, dac_data, busy, underflow, under_count, irq
    );
endinterface

// File: rtl/transmission.sv
// transmission: buffers {Q,I} frames in a FIFO and plays them to the DAC as preamble, payload, zero gap.
// WIPHY_TX_PREAMBLE_EN enables the preamble generator; without it frames start straight at the payload.
module transmission #(
`ifdef WIPHY_TX_PREAMBLE_EN
    parameter int          PREAMBLE_LEN = 160,
    parameter logic [15:0] AMP          = 16'h2000,
`endif
    parameter int          DEPTH        = 16,
    parameter int          GAP_LEN      = 16
) (
    input  logic          clk,
    input  logic          reset,
    transmission_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] P_ONE = 1;
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;
    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_under;
    logic [31:0] r_dac;
    logic        r_uf;
    logic        r_irq;
    logic [32:0] r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [32:0] w_head;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty         = r_wp == r_rp;
    assign w_full          = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push          = bus.s_valid && !w_full;
    assign w_pop           = bus.dac_valid && r_state == PAYLOAD && !w_empty;
    assign w_head          = r_mem[r_rp[AW-1:0]];
    assign bus.s_ready     = !w_full;
    assign bus.dac_data    = r_dac;
    assign bus.busy        = r_state != IDLE;
    assign bus.underflow   = r_uf;
    assign bus.under_count = r_under;
    assign bus.irq         = r_irq;
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp[AW-1:0]] <= {bus.s_last, bus.s_data};
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_under <= '0;
            r_dac   <= '0;
            r_uf    <= 1'b0;
            r_irq   <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
        end else begin
            r_uf  <= 1'b0;
            r_irq <= 1'b0;
            if (w_push) r_wp <= r_wp + P_ONE;
            if (w_pop) r_rp <= r_rp + P_ONE;
            if (bus.dac_valid) begin
                case (r_state)
                    IDLE: begin
                        r_dac <= '0;
                        if (!w_empty) begin
                            r_cnt <= '0;
`ifdef WIPHY_TX_PREAMBLE_EN
                            r_state <= PREAMBLE;
`else
                            r_state <= PAYLOAD;
`endif
                        end
                    end
`ifdef WIPHY_TX_PREAMBLE_EN
                    PREAMBLE: begin
                        r_dac <= {16'h0000, r_cnt[3] ? -AMP : AMP};
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == 16'(PREAMBLE_LEN - 1)) r_state <= PAYLOAD;
                    end
`endif
                    PAYLOAD: begin
                        r_dac <= w_empty ? 32'h0 : w_head[31:0];
                        r_uf  <= w_empty;
                        if (w_empty && r_under != 16'hFFFF) r_under <= r_under + 16'd1;
                        if (!w_empty && w_head[32]) begin
                            r_cnt   <= '0;
                            r_state <= GAP;
                        end
                    end
                    GAP: begin
                        r_dac <= '0;
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == 16'(GAP_LEN - 1)) begin
                            r_state <= IDLE;
                            r_irq   <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_transmission.sv
// tb_transmission: table-driven and randomized checks of the transmit frame player against a sample-stream model.
module tb_transmission;
    localparam int DEPTH = 16;
    localparam int PL    = 4;
    localparam int GL    = 2;
`ifdef WIPHY_TX_PREAMBLE_EN
    localparam int NPRE = PL;
`else
    localparam int NPRE = 0;
`endif
    typedef struct packed {logic [31:0] d; logic irq; logic uf;} samp_t;
    typedef struct packed {logic dv; logic [31:0] d; logic irq; logic busy;} vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    transmission_if bus();
`ifdef WIPHY_TX_PREAMBLE_EN
    transmission #(.PREAMBLE_LEN(PL), .AMP(16'h2000), .DEPTH(DEPTH), .GAP_LEN(GL)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`else
    transmission #(.DEPTH(DEPTH), .GAP_LEN(GL)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif
    int          checks = 0;
    int          errors = 0;
    samp_t       exp_q[$];
    logic [31:0] pl_q[$];
    int unsigned uc_m;
    logic [31:0] last_d;
    // Preamble sign flips every 8 samples: I = +AMP for samples 0-7, -AMP for 8-15, and so on.
    function automatic logic [31:0] pre_val(int c);
        return ((c % 16) >= 8) ? 32'h0000E000 : 32'h00002000;
    endfunction
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h, want %h at %0t", n, a, e, $time);
        end
    endtask
    task automatic add_frame;
        exp_q.push_back({32'h0, 1'b0, 1'b0});
        for (int c = 0; c < NPRE; c++) exp_q.push_back({pre_val(c), 1'b0, 1'b0});
        foreach (pl_q[i]) exp_q.push_back({pl_q[i], 1'b0, 1'b0});
        for (int g = 0; g < GL; g++) exp_q.push_back({32'h0, 1'(g == GL - 1), 1'b0});
        pl_q.delete();
    endtask
    task automatic dv_step(input logic dv);
        samp_t e;
        bus.dac_valid = dv;
        @(posedge clk);
        #1;
        if (dv) begin
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (e.uf && uc_m < 32'hFFFF) uc_m++;
            last_d = e.d;
            chk("dac_data", bus.dac_data, e.d);
            chk("irq", 32'(bus.irq), 32'(e.irq));
            chk("underflow", 32'(bus.underflow), 32'(e.uf));
            chk("under_count", 32'(bus.under_count), uc_m);
        end else begin
            chk("dac_hold", bus.dac_data, last_d);
            chk("irq_idle", 32'(bus.irq), 32'h0);
            chk("underflow_idle", 32'(bus.underflow), 32'h0);
        end
    endtask
    task automatic push_word(input logic [31:0] d, input logic l);
        bus.s_valid   = 1'b1;
        bus.s_data    = d;
        bus.s_last    = l;
        bus.dac_valid = 1'b0;
        chk("s_ready_push", 32'(bus.s_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask
    task automatic do_reset;
        reset         = 1'b1;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.dac_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_dac_data", bus.dac_data, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_irq", 32'(bus.irq), 32'h0);
        chk("rst_underflow", 32'(bus.underflow), 32'h0);
        chk("rst_under_count", 32'(bus.under_count), 32'h0);
        reset = 1'b0;
        exp_q.delete();
        uc_m   = 0;
        last_d = '0;
        chk("rst_s_ready", 32'(bus.s_ready), 32'h1);
    endtask
    initial begin : main
        vec_t tbl[$];
        int   guard;
        int   nfr;
        int   len;
        tbl.push_back({1'b1, 32'h0, 1'b0, 1'b1});
        for (int c = 0; c < NPRE; c++) tbl.push_back({1'b1, pre_val(c), 1'b0, 1'b1});
        tbl.push_back({1'b1, 32'h00010001, 1'b0, 1'b1});
        tbl.push_back({1'b0, 32'h00010001, 1'b0, 1'b1});
        tbl.push_back({1'b1, 32'h00020002, 1'b0, 1'b1});
        tbl.push_back({1'b1, 32'h00030003, 1'b0, 1'b1});
        for (int g = 0; g < GL; g++) tbl.push_back({1'b1, 32'h0, 1'(g == GL - 1), 1'(g != GL - 1)});
        tbl.push_back({1'b1, 32'h0, 1'b0, 1'b0});
        tbl.push_back({1'b1, 32'h0, 1'b0, 1'b0});
        // No input, DAC strobing every cycle: silence, never busy.
        do_reset();
        repeat (20) begin
            dv_step(1'b1);
            chk("idle_busy", 32'(bus.busy), 32'h0);
            chk("idle_s_ready", 32'(bus.s_ready), 32'h1);
        end
        // Three-sample frame applied from the vector table.
        do_reset();
        push_word(32'h00010001, 1'b0);
        push_word(32'h00020002, 1'b0);
        push_word(32'h00030003, 1'b1);
        foreach (tbl[i]) begin
            bus.dac_valid = tbl[i].dv;
            @(posedge clk);
            #1;
            chk("tbl_dac_data", bus.dac_data, tbl[i].d);
            chk("tbl_irq", 32'(bus.irq), 32'(tbl[i].irq));
            chk("tbl_busy", 32'(bus.busy), 32'(tbl[i].busy));
            chk("tbl_underflow", 32'(bus.underflow), 32'h0);
        end
        // Payload starvation: frame without last, source stalls.
        do_reset();
        push_word(32'hAAAA0001, 1'b0);
        push_word(32'hBBBB0002, 1'b0);
        exp_q.push_back({32'h0, 1'b0, 1'b0});
        for (int c = 0; c < NPRE; c++) exp_q.push_back({pre_val(c), 1'b0, 1'b0});
        exp_q.push_back({32'hAAAA0001, 1'b0, 1'b0});
        exp_q.push_back({32'hBBBB0002, 1'b0, 1'b0});
        repeat (5) exp_q.push_back({32'h0, 1'b0, 1'b1});
        for (int i = 0; i < 3 + NPRE + 2; i++) dv_step(1'b1);
        dv_step(1'b0);
        repeat (3) dv_step(1'b1);
        // Fill to DEPTH with the DAC idle, hold off one more word, then release by popping.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_s_ready", 32'(bus.s_ready), 32'h1);
            bus.s_valid = 1'b1;
            bus.s_data  = 32'(i + 1);
            bus.s_last  = 1'b0;
            dv_step(1'b0);
            pl_q.push_back(32'(i + 1));
        end
        chk("full_s_ready", 32'(bus.s_ready), 32'h0);
        bus.s_data = 32'd17;
        bus.s_last = 1'b1;
        pl_q.push_back(32'd17);
        add_frame();
        repeat (3) begin
            dv_step(1'b0);
            chk("held_s_ready", 32'(bus.s_ready), 32'h0);
        end
        for (int j = 0; j < NPRE + 2; j++) begin
            chk("prepop_s_ready", 32'(bus.s_ready), 32'h0);
            dv_step(1'b1);
        end
        chk("postpop_s_ready", 32'(bus.s_ready), 32'h1);
        dv_step(1'b0);
        bus.s_valid = 1'b0;
        chk("refull_s_ready", 32'(bus.s_ready), 32'h0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            dv_step(1'b1);
            guard++;
        end
        chk("fill_drained", 32'(exp_q.size()), 32'h0);
        chk("fill_busy_end", 32'(bus.busy), 32'h0);
        // Reset while starving in PAYLOAD.
        do_reset();
        push_word(32'h12345678, 1'b0);
        exp_q.push_back({32'h0, 1'b0, 1'b0});
        for (int c = 0; c < NPRE; c++) exp_q.push_back({pre_val(c), 1'b0, 1'b0});
        exp_q.push_back({32'h12345678, 1'b0, 1'b0});
        repeat (2) exp_q.push_back({32'h0, 1'b0, 1'b1});
        for (int i = 0; i < NPRE + 4; i++) dv_step(1'b1);
        chk("pre_rst_busy", 32'(bus.busy), 32'h1);
        reset         = 1'b1;
        bus.dac_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_dac_data", bus.dac_data, 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_irq", 32'(bus.irq), 32'h0);
        chk("midrst_under_count", 32'(bus.under_count), 32'h0);
        chk("midrst_s_ready", 32'(bus.s_ready), 32'h1);
        reset = 1'b0;
        exp_q.delete();
        uc_m   = 0;
        last_d = '0;
        repeat (5) begin
            dv_step(1'b1);
            chk("midrst_empty_busy", 32'(bus.busy), 32'h0);
        end
        // One-sample frame, then randomized multi-frame bursts with a random DAC strobe.
        do_reset();
        push_word(32'h7FFF8000, 1'b1);
        pl_q.push_back(32'h7FFF8000);
        add_frame();
        for (int it = 0; it < 10; it++) begin
            nfr = int'($urandom_range(1, 3));
            for (int f = 0; f < nfr; f++) begin
                len = int'($urandom_range(1, 5));
                for (int s = 0; s < len; s++) begin
                    repeat ($urandom_range(0, 2)) dv_step(1'b0);
                    pl_q.push_back($urandom);
                    push_word(pl_q[s], 1'(s == len - 1));
                end
                add_frame();
            end
            guard = 0;
            while (exp_q.size() > 0 && guard < 1000) begin
                dv_step(1'($urandom_range(0, 1)));
                guard++;
            end
            chk("rand_drained", 32'(exp_q.size()), 32'h0);
            repeat (3) dv_step(1'b1);
            chk("rand_busy_end", 32'(bus.busy), 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
